pwl_stream_engine: RTL and testbench
====================================

Name: pwl_stream_engine

Overview:
- Runtime-programmable piecewise-linear activation engine.
- The fixed-LUT activation blocks only consume a sample and apply hard-wired segments. This block carries both ends of the segment table: a configuration write port that loads segments, and a streaming valid/ready evaluator that reads them back.
- It sits between the MAC array output and the writeback buffer. Firmware loads SiLU, GELU, sigmoid and similar tables without a re-synthesis.
- All data is signed Q8.8 (0x0100 = 1.0).

Parameters:
- NSEG, 16, number of table segments (power of two, >= 2).
- AW, $clog2(NSEG), segment index width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  segment write strobe
- cfg_addr  in  AW  segment index
- cfg_bp  in  16  segment lower-bound breakpoint, signed Q8.8
- cfg_delta  in  16  x offset subtracted before the shift
- cfg_shift  in  4  arithmetic right shift, i.e. slope 2^-shift
- cfg_zero  in  1  1 = slope term forced to 0 (constant segment)
- cfg_bias  in  16  additive bias, Q8.8
- cfg_busy  out  1  high while a sample is in flight; writes are ignored while high
- in_valid  in  1  input sample valid
- in_ready  out  1  engine can accept a sample
- in_x  in  16  input sample, Q8.8
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_y  out  16  result, Q8.8

Behaviour:
- Reset state:
  - FSM = IDLE, in_ready=1, out_valid=0, out_y=0, cfg_busy=0.
  - Every table entry is set to bp=0x8000, delta=0, shift=0, zero=0, bias=0, so the engine computes identity (y = x).
- Table writes:
  - Accepted on a clk edge when cfg_we=1 and FSM = IDLE.
  - A write is visible to a sample accepted on the following cycle.
  - cfg_we while cfg_busy=1 is dropped silently.
  - A write and a sample accept on the same edge: the write lands, and that sample uses the pre-write table.
- FSM states: IDLE -> SEARCH -> CALC -> HOLD -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch x, idx=0, bit counter = AW-1, go to SEARCH. cfg_busy=1 from the next cycle.
- SEARCH (AW cycles):
  - Each cycle forms cand = idx | (1<<b).
  - If signed bp[cand] <= x, then idx = cand.
  - b decrements; after b=0, go to CALC.
  - Entry 0's bp is never compared; entry 0 catches all x below bp[1].
  - Breakpoints are programmed ascending. For an unsorted table the result is exactly what this algorithm produces.
- CALC (1 cycle), using entry[idx]:
  - d = x - delta, 16-bit wrap.
  - t = zero ? 0 : (d >>> shift), arithmetic shift, sign-extended.
  - y = t + bias, 16-bit wrap.
  - Register y into out_y, set out_valid=1, go to HOLD.
- HOLD:
  - out_y and out_valid are held stable until out_ready.
  - On out_valid & out_ready: out_valid=0, cfg_busy=0, return to IDLE.
  - in_ready becomes 1 on the next cycle; there is no accept-in-same-cycle bypass.
- Latency:
  - Accept edge E0; out_valid is high after edge E0+AW+1 (E0+5 for NSEG=16).
  - Throughput is one sample per AW+3 cycles with out_ready tied high.
- in_ready=0 in SEARCH, CALC and HOLD.
- rst asserted mid-operation aborts the sample and returns to the full reset state, including the table.

Optional Feature:
- Macro PWL_SATURATE_EN.
- Defined:
  - d, t and y are computed at 17 bits.
  - y is clamped to 0x7FFF on positive overflow and 0x8000 on negative overflow.
  - d is not clamped.
- Undefined: plain 16-bit two's-complement wrap, as specified above.

Decomposition:
- Package pwl_pkg holds:
  - Q8.8 constants: ONE = 16'h0100, MAXV = 16'h7FFF, MINV = 16'h8000.
  - Segment entry struct: bp, delta, shift, zero, bias; 53 bits.
  - Reset/identity entry constant.
  - FSM state enum.
- Sub-module pwl_seg_eval: the combinational CALC datapath (delta subtract, shift, zero mux, bias add, optional saturation).
  - Instantiated once.
  - Reused by the fixed-function activation blocks later.

Test Plan:
- Post-reset identity: in_x=0x0180, 0xFE00, 0x7FFF -> out_y equals in_x; out_valid appears exactly 5 cycles after each accept.
- SiLU-style table:
  - Load entry 0 = {zero=1, bias=0}, entry 1 = {bp 0xFFC0, delta 0xFF80, shift 1, bias 0xFFC3}, entries 2..15 bp = 0x7FFF.
  - in_x=0x0000 -> out_y=0x0003.
  - in_x=0xF700 -> out_y=0x0000.
- Backpressure: hold out_ready=0 for 10 cycles -> out_y and out_valid stable, in_ready=0 throughout; result accepted on the first out_ready cycle, in_ready=1 on the next cycle.
- Config while busy: cfg_we to entry 0 during SEARCH is ignored; the next sample still sees the old entry; the same write issued in IDLE takes effect.
- Reset mid-SEARCH: assert rst for 1 cycle -> out_valid=0, in_ready=1, table back to identity; in_x=0x1234 -> out_y=0x1234.
- Overflow: single segment {delta 0, shift 0, bias 0x7000}, in_x=0x2000 -> out_y=0x9000 without PWL_SATURATE_EN, 0x7FFF with it.

Source files
------------

// File: rtl/pwl_pkg.sv
// pwl_pkg: shared types and constants for the PWL activation engine.
// All data values are signed Q8.8.
package pwl_pkg;

  localparam logic [15:0] ONE  = 16'h0100;
  localparam logic [15:0] MAXV = 16'h7FFF;
  localparam logic [15:0] MINV = 16'h8000;

  typedef struct packed {
    logic [15:0] bp;
    logic [15:0] delta;
    logic [3:0]  shift;
    logic        zero;
    logic [15:0] bias;
  } seg_t;

  // Identity segment: lowest possible bound, y = x.
  localparam seg_t SEG_RST = '{
    bp:    MINV,
    delta: 16'h0000,
    shift: 4'd0,
    zero:  1'b0,
    bias:  16'h0000
  };

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    CALC,
    HOLD
  } state_t;

endpackage

// File: rtl/pwl_seg_eval.sv
// pwl_seg_eval: one PWL segment, y = ((x - delta) >>> shift) + bias.
// Macro PWL_SATURATE_EN: 17-bit math with clamp of the result.
module pwl_seg_eval
  import pwl_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] delta,
  input  logic [3:0]  shift,
  input  logic        zero,
  input  logic [15:0] bias,
  output logic [15:0] y
);

`ifdef PWL_SATURATE_EN
  logic signed [16:0] d;
  logic signed [16:0] t;
  logic signed [16:0] s;

  // Wide datapath; only the final sum is clamped.
  always_comb begin
    d = $signed({x[15], x}) - $signed({delta[15], delta});
    t = zero ? 17'sd0 : (d >>> shift);
    s = t + $signed({bias[15], bias});
    if (s[16] != s[15]) begin
      y = s[16] ? MINV : MAXV;
    end else begin
      y = s[15:0];
    end
  end
`else
  logic signed [15:0] d;
  logic signed [15:0] t;

  // Plain two's-complement wrap at 16 bits.
  always_comb begin
    d = $signed(x) - $signed(delta);
    t = zero ? 16'sd0 : (d >>> shift);
    y = t + $signed(bias);
  end
`endif

endmodule

// File: rtl/pwl_stream_engine.sv
// pwl_stream_engine: programmable PWL activation, binary segment search.
// Macro PWL_SATURATE_EN selects the clamping evaluator.
module pwl_stream_engine
  import pwl_pkg::*;
#(
  parameter  int NSEG = 16,
  localparam int AW   = $clog2(NSEG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [15:0]   cfg_bp,
  input  logic [15:0]   cfg_delta,
  input  logic [3:0]    cfg_shift,
  input  logic          cfg_zero,
  input  logic [15:0]   cfg_bias,
  output logic          cfg_busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_y
);

  state_t        state;
  seg_t          tbl [NSEG];
  seg_t          shadow;
  logic          shadow_v;
  logic [AW-1:0] shadow_a;
  logic [15:0]   x_q;
  logic [AW-1:0] idx;
  logic [AW-1:0] bcnt;
  logic [AW-1:0] cand;
  logic [15:0]   cand_bp;
  logic          cur_sel;
  logic [15:0]   cur_delta;
  logic [3:0]    cur_shift;
  logic          cur_zero;
  logic [15:0]   cur_bias;
  logic [15:0]   y_calc;
  logic          accept;
  logic          wr_en;
  seg_t          wr_seg;

  assign accept = (state == IDLE) && in_valid;
  assign wr_en  = (state == IDLE) && cfg_we;
  assign wr_seg = '{
    bp:    cfg_bp,
    delta: cfg_delta,
    shift: cfg_shift,
    zero:  cfg_zero,
    bias:  cfg_bias
  };

  // Table reads; the shadow copy stands in for an entry overwritten
  // on the same edge the current sample was accepted.
  always_comb begin
    cand       = idx;
    cand[bcnt] = 1'b1;
    cand_bp    = (shadow_v && shadow_a == cand) ?
                 shadow.bp : tbl[cand].bp;
    cur_sel    = shadow_v && (shadow_a == idx);
    cur_delta  = cur_sel ? shadow.delta : tbl[idx].delta;
    cur_shift  = cur_sel ? shadow.shift : tbl[idx].shift;
    cur_zero   = cur_sel ? shadow.zero  : tbl[idx].zero;
    cur_bias   = cur_sel ? shadow.bias  : tbl[idx].bias;
  end

  pwl_seg_eval u_eval (
    .x     (x_q),
    .delta (cur_delta),
    .shift (cur_shift),
    .zero  (cur_zero),
    .bias  (cur_bias),
    .y     (y_calc)
  );

  // Segment table writes and pre-write snapshot for a same-edge accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        tbl[i] <= SEG_RST;
      end
      shadow   <= SEG_RST;
      shadow_v <= 1'b0;
      shadow_a <= '0;
    end else begin
      if (wr_en) begin
        tbl[cfg_addr] <= wr_seg;
      end
      if (accept) begin
        shadow_v <= wr_en;
        shadow_a <= cfg_addr;
        shadow   <= tbl[cfg_addr];
      end
    end
  end

  // Sample FSM: accept, binary search, evaluate, hold for handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_y     <= '0;
      cfg_busy  <= 1'b0;
      x_q       <= '0;
      idx       <= '0;
      bcnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_q      <= in_x;
            idx      <= '0;
            bcnt     <= AW'(AW - 1);
            in_ready <= 1'b0;
            cfg_busy <= 1'b1;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          if ($signed(cand_bp) <= $signed(x_q)) begin
            idx <= cand;
          end
          if (bcnt == '0) begin
            state <= CALC;
          end else begin
            bcnt <= bcnt - 1'b1;
          end
        end
        CALC: begin
          out_y     <= y_calc;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cfg_busy  <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwl_stream_engine.sv
// tb_pwl_stream_engine: directed checks of the PWL stream engine.
// Expected values are hand-computed Q8.8 results.
module tb_pwl_stream_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_bp = '0;
  logic [15:0] cfg_delta = '0;
  logic [3:0]  cfg_shift = '0;
  logic        cfg_zero = 1'b0;
  logic [15:0] cfg_bias = '0;
  logic        cfg_busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_y;

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pwl_stream_engine #(.NSEG(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_bp    (cfg_bp),
    .cfg_delta (cfg_delta),
    .cfg_shift (cfg_shift),
    .cfg_zero  (cfg_zero),
    .cfg_bias  (cfg_bias),
    .cfg_busy  (cfg_busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [3:0] a, input logic [15:0] bp,
                         input logic [15:0] dl, input logic [3:0] sh,
                         input logic z, input logic [15:0] bi);
    cfg_addr  = a;
    cfg_bp    = bp;
    cfg_delta = dl;
    cfg_shift = sh;
    cfg_zero  = z;
    cfg_bias  = bi;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] bp,
                           input logic [15:0] dl, input logic [3:0] sh,
                           input logic z, input logic [15:0] bi);
    @(negedge clk);
    set_cfg(a, bp, dl, sh, z, bi);
    cfg_we = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic start_sample(input logic [15:0] x);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk);
      #1 g++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_x = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    chk("busy_after_acc", {30'd0, cfg_busy, in_ready}, 32'd2);
  endtask

  task automatic finish_sample(input string tag, input logic [15:0] exp,
                               input int already, input int hold);
    int n;
    n = already;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_lat"}, n, 5);
    chk(tag, {16'd0, out_y}, {16'd0, exp});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold"}, {out_valid, in_ready, out_y},
          {1'b1, 1'b0, exp});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_done"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_state", {in_ready, out_valid, cfg_busy, out_y},
        {1'b1, 1'b0, 1'b0, 16'h0000});

    start_sample(16'h0180); finish_sample("id_0180", 16'h0180, 0, 0);
    start_sample(16'hFE00); finish_sample("id_fe00", 16'hFE00, 0, 0);
    start_sample(16'h7FFF); finish_sample("id_7fff", 16'h7FFF, 0, 0);

    cfg_write(4'd0, 16'h8000, 16'h0000, 4'd0, 1'b1, 16'h0000);
    cfg_write(4'd1, 16'hFFC0, 16'hFF80, 4'd1, 1'b0, 16'hFFC3);
    for (int i = 2; i < 16; i++) begin
      cfg_write(4'(i), 16'h7FFF, 16'h0000, 4'd0, 1'b0, 16'h0000);
    end
    start_sample(16'h0000); finish_sample("silu_0", 16'h0003, 0, 0);
    start_sample(16'hF700); finish_sample("silu_f7", 16'h0000, 0, 0);
    start_sample(16'h1234); finish_sample("silu_1234", 16'h091D, 0, 0);

    start_sample(16'h0000); finish_sample("bp", 16'h0003, 0, 10);

    start_sample(16'hF700);
    cfg_write(4'd0, 16'h8000, 16'h0000, 4'd0, 1'b1, 16'h0100);
    finish_sample("busy_wr", 16'h0000, 1, 0);
    start_sample(16'hF700); finish_sample("busy_wr2", 16'h0000, 0, 0);
    cfg_write(4'd0, 16'h8000, 16'h0000, 4'd0, 1'b1, 16'h0100);
    start_sample(16'hF700); finish_sample("idle_wr", 16'h0100, 0, 0);

    set_cfg(4'd0, 16'h8000, 16'h0000, 4'd0, 1'b1, 16'h0200);
    cfg_we = 1'b1;
    start_sample(16'hF700); finish_sample("same_edge", 16'h0100, 0, 0);
    start_sample(16'hF700); finish_sample("same_next", 16'h0200, 0, 0);

    start_sample(16'h0000);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst", {out_valid, in_ready, cfg_busy}, {1'b0, 1'b1, 1'b0});
    start_sample(16'h1234); finish_sample("rst_id", 16'h1234, 0, 0);

    for (int i = 0; i < 16; i++) begin
      cfg_write(4'(i), 16'h8000, 16'h0000, 4'd0, 1'b0, 16'h7000);
    end
    start_sample(16'h2000);
`ifdef PWL_SATURATE_EN
    finish_sample("ovf", 16'h7FFF, 0, 0);
`else
    finish_sample("ovf", 16'h9000, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
